alu_rr_sequencer: RTL and testbench

//   Shares one combinational 8-bit ALU (4-bit opcode; a, b in; y, overflow out) between two requesters.

---
 rtl/alu_rr_sequencer.sv | 137 +++++++++++++
 tb/tb_alu_rr_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_sequencer.sv
// Round-robin sequencer that shares one combinational ALU between two requesters.
// Optional macro DIV0_CHECK_EN: short-circuits DIV with b==0 into an error response.
module alu_rr_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_opcode,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_opcode,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_y,
    output logic             resp_zero,
    output logic             resp_ovf,
    output logic             resp_err,
    output logic [OPW-1:0]   alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_overflow
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state, state_nx;
    logic             prio;
    logic             grant_id;
    logic             accept;
    logic             div0;
    logic [OPW-1:0]   sel_opcode;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // prio names the requester that wins when both are valid
    assign grant_id   = req0_valid ? (req1_valid ? prio : 1'b0) : 1'b1;
    assign sel_opcode = grant_id ? req1_opcode : req0_opcode;
    assign sel_a      = grant_id ? req1_a : req0_a;
    assign sel_b      = grant_id ? req1_b : req0_b;

`ifdef DIV0_CHECK_EN
    localparam logic [OPW-1:0] OP_DIV = OPW'(3);
    logic err_q;
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        accept     = 1'b0;
        div0       = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept     = 1'b1;
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
`ifdef DIV0_CHECK_EN
                    div0       = (sel_opcode == OP_DIV) && (sel_b == '0);
`endif
                    state_nx   = div0 ? RESP : EXEC;
                end
            end
            EXEC:    state_nx = RESP;
            RESP:    if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand issue, arbitration pointer and response capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio       <= 1'b0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_y     <= '0;
            resp_zero  <= 1'b0;
            resp_ovf   <= 1'b0;
`ifdef DIV0_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            if (accept) begin
                alu_opcode <= sel_opcode;
                alu_a      <= sel_a;
                alu_b      <= sel_b;
                resp_id    <= grant_id;
                prio       <= ~grant_id;
            end
            if (div0) begin
                resp_valid <= 1'b1;
                resp_y     <= '0;
                resp_zero  <= 1'b1;
                resp_ovf   <= 1'b0;
`ifdef DIV0_CHECK_EN
                err_q      <= 1'b1;
`endif
            end
            if (state == EXEC) begin
                resp_valid <= 1'b1;
                resp_y     <= alu_y;
                resp_zero  <= (alu_y == '0);
                resp_ovf   <= alu_overflow;
`ifdef DIV0_CHECK_EN
                err_q      <= 1'b0;
`endif
            end
            if (state == RESP && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Bench for alu_rr_sequencer: directed scenarios plus random traffic against a
// transaction-level model (grant order, response timing, expected ALU results).
module tb_alu_rr_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_opcode = '0, req1_opcode = '0;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       resp_valid, resp_id, resp_zero, resp_ovf, resp_err;
    logic       resp_ready = 1'b1;
    logic [7:0] resp_y;
    logic [3:0] alu_opcode;
    logic [7:0] alu_a, alu_b, alu_y;
    logic       alu_overflow;

    always #5 clk = ~clk;

    alu_rr_sequencer #(.WIDTH(8), .OPW(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_y(resp_y), .resp_zero(resp_zero), .resp_ovf(resp_ovf), .resp_err(resp_err),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_y(alu_y), .alu_overflow(alu_overflow)
    );

    // External ALU: ADD, SUB, AND, DIV, XOR for everything else; returns {ovf, y}
    function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] y;
        logic       ov;
        ov = 1'b0;
        case (op)
            4'd0: begin y = a + b; ov = (a[7] == b[7]) && (y[7] != a[7]); end
            4'd1: begin y = a - b; ov = (a[7] != b[7]) && (y[7] != a[7]); end
            4'd2: y = a & b;
            4'd3: begin y = (b == 8'd0) ? 8'hFF : a / b; ov = (b == 8'd0); end
            default: y = a ^ b;
        endcase
        return {ov, y};
    endfunction

    assign {alu_overflow, alu_y} = alu_fn(alu_opcode, alu_a, alu_b);

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model
    int         cyc = 0;
    bit         busy = 0;
    int         vis_cyc = 0;
    bit         prio = 0;
    bit         acc0 = 0, acc1 = 0;
    logic [3:0] m_op = '0;
    logic [7:0] m_a = '0, m_b = '0;
    logic       e_id = 0, e_zero = 0, e_ovf = 0, e_err = 0;
    logic [7:0] e_y = '0;

    // One clock cycle: check outputs, predict the edge, advance to the next negedge
    task automatic step();
        int  g;
        bit  vis;
        bit  d0;
        logic [8:0] r;
        #1;
        g = -1;
        if (!busy) begin
            if (req0_valid && req1_valid) g = int'(prio);
            else if (req0_valid)          g = 0;
            else if (req1_valid)          g = 1;
        end
        chk("req0_ready", 32'(req0_ready), 32'(g == 0));
        chk("req1_ready", 32'(req1_ready), 32'(g == 1));
        vis = busy && (cyc >= vis_cyc);
        chk("resp_valid", 32'(resp_valid), 32'(vis));
        if (vis) begin
            chk("resp_id",   32'(resp_id),   32'(e_id));
            chk("resp_y",    32'(resp_y),    32'(e_y));
            chk("resp_zero", 32'(resp_zero), 32'(e_zero));
            chk("resp_ovf",  32'(resp_ovf),  32'(e_ovf));
            chk("resp_err",  32'(resp_err),  32'(e_err));
        end
        chk("alu_regs", 32'({alu_opcode, alu_a, alu_b}), 32'({m_op, m_a, m_b}));
        @(posedge clk);
        cyc++;
        acc0 = (g == 0);
        acc1 = (g == 1);
        if (vis && resp_ready) busy = 0;
        if (g >= 0) begin
            m_op = (g == 1) ? req1_opcode : req0_opcode;
            m_a  = (g == 1) ? req1_a : req0_a;
            m_b  = (g == 1) ? req1_b : req0_b;
            prio = (g == 0);
            busy = 1;
            r      = alu_fn(m_op, m_a, m_b);
            e_id   = (g == 1);
            e_y    = r[7:0];
            e_ovf  = r[8];
            e_zero = (r[7:0] == 8'd0);
            e_err  = 1'b0;
            d0     = 0;
`ifdef DIV0_CHECK_EN
            if (m_op == 4'd3 && m_b == 8'd0) begin
                d0 = 1; e_y = 8'd0; e_zero = 1'b1; e_ovf = 1'b0; e_err = 1'b1;
            end
`endif
            vis_cyc = cyc + (d0 ? 0 : 1);
        end
        @(negedge clk);
    endtask

    task automatic set_req(input int n, input bit v, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        if (n == 0) begin req0_valid = v; req0_opcode = op; req0_a = a; req0_b = b; end
        else        begin req1_valid = v; req1_opcode = op; req1_a = a; req1_b = b; end
    endtask

    task automatic do_reset();
        req0_valid = 0;
        req1_valid = 0;
        rst = 1;
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp", 32'({resp_id, resp_y, resp_zero, resp_ovf, resp_err}), 32'd0);
        chk("rst_alu_regs", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
        busy = 0; prio = 0; m_op = '0; m_a = '0; m_b = '0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic drain();
        int k;
        req0_valid = 0;
        req1_valid = 0;
        resp_ready = 1;
        k = 0;
        while (busy && k < 10) begin step(); k++; end
        chk("drain_timeout", 32'(busy), 32'd0);
    endtask

    // Single op with a held response, then fixed-value checks
    task automatic directed_op(input string tag, input int n, input logic [3:0] op, input logic [7:0] a,
                               input logic [7:0] b, input logic [7:0] ey, input bit ez, input bit eo, input bit ee);
        resp_ready = 0;
        set_req(n, 1, op, a, b);
        step();
        set_req(n, 0, 4'd0, 8'd0, 8'd0);
        step();
        step();
        #1;
        chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_flags"}, 32'({resp_id, resp_y, resp_zero, resp_ovf, resp_err}),
            32'({1'(n), ey, ez, eo, ee}));
        resp_ready = 1;
        step();
        step();
    endtask

    initial begin
        int grants[$];
        int gcyc[$];
        int k;
        @(negedge clk);
        do_reset();

        // Basic ADD with latency check
        resp_ready = 1;
        set_req(0, 1, 4'd0, 8'h05, 8'h03);
        step();
        chk("t1_accepted", 32'(acc0), 32'd1);
        set_req(0, 0, 4'd0, 8'h00, 8'h00);
        #1;
        chk("t1_not_yet", 32'(resp_valid), 32'd0);
        step();
        #1;
        chk("t1_valid", 32'(resp_valid), 32'd1);
        chk("t1_y", 32'({resp_id, resp_y, resp_zero, resp_ovf}), 32'({1'b0, 8'h08, 1'b0, 1'b0}));
        step();
        step();

        directed_op("t2_add", 1, 4'd0, 8'h70, 8'h70, 8'hE0, 1'b0, 1'b1, 1'b0);
        directed_op("t2_sub", 1, 4'd1, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0);

        // Both valid continuously: alternating grants, 3 cycles apart
        resp_ready = 1;
        set_req(0, 1, 4'(($urandom % 3)), 8'($urandom), 8'($urandom));
        set_req(1, 1, 4'(($urandom % 3)), 8'($urandom), 8'($urandom));
        k = 0;
        while (grants.size() < 4 && k < 20) begin
            step();
            k++;
            if (acc0) begin grants.push_back(0); gcyc.push_back(cyc); set_req(0, 1, 4'($urandom % 3), 8'($urandom), 8'($urandom)); end
            if (acc1) begin grants.push_back(1); gcyc.push_back(cyc); set_req(1, 1, 4'($urandom % 3), 8'($urandom), 8'($urandom)); end
        end
        chk("t3_grant_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < grants.size(); i++) begin
            chk("t3_grant_order", 32'(grants[i]), 32'(i % 2));
            if (i > 0) chk("t3_interval", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
        end
        drain();

        // Stalled response: held stable, no grants while busy
        resp_ready = 0;
        set_req(0, 1, 4'd4, 8'h3C, 8'h0F);
        step();
        set_req(0, 0, 4'd0, 8'd0, 8'd0);
        set_req(1, 1, 4'd2, 8'hF0, 8'h3C);
        repeat (6) step();
        chk("t4_no_grant", 32'(acc1), 32'd0);
        resp_ready = 1;
        step();
        step();
        chk("t4_accept_after", 32'(acc1), 32'd1);
        set_req(1, 0, 4'd0, 8'd0, 8'd0);
        drain();

        // Reset during EXEC: response dropped, pointer back to req0
        set_req(0, 1, 4'd0, 8'h11, 8'h22);
        step();
        set_req(0, 0, 4'd0, 8'd0, 8'd0);
        do_reset();
        resp_ready = 1;
        set_req(0, 1, 4'd1, 8'h40, 8'h01);
        set_req(1, 1, 4'd0, 8'h02, 8'h03);
        step();
        chk("t5_req0_first", 32'(acc0), 32'd1);
        set_req(0, 0, 4'd0, 8'd0, 8'd0);
        set_req(1, 0, 4'd0, 8'd0, 8'd0);
        drain();

`ifdef DIV0_CHECK_EN
        directed_op("t6_div0", 0, 4'd3, 8'h20, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
`else
        directed_op("t6_div0", 0, 4'd3, 8'h20, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
`endif
        directed_op("t6_div", 1, 4'd3, 8'h21, 8'h04, 8'h08, 1'b0, 1'b0, 1'b0);

        // Random traffic; requesters hold until accepted
        for (int i = 0; i < 400; i++) begin
            if (!req0_valid && ($urandom % 2 == 0))
                set_req(0, 1, 4'($urandom % 6), 8'($urandom), ($urandom % 4 == 0) ? 8'd0 : 8'($urandom));
            if (!req1_valid && ($urandom % 2 == 0))
                set_req(1, 1, 4'($urandom % 6), 8'($urandom), ($urandom % 4 == 0) ? 8'd0 : 8'($urandom));
            resp_ready = ($urandom % 4 != 0);
            step();
            if (acc0) req0_valid = 0;
            if (acc1) req1_valid = 0;
        end
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
